// File: rtl/seq_gen_pkg.sv
// Shared types and limits for the seq_pattern_gen event-bus stimulus generator.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      MODE_A   = 2'b00,
      MODE_B   = 2'b01,
      MODE_AND = 2'b10
   } mode_e;

   localparam int unsigned GAP_MAX = 15;
   localparam int unsigned TIMER_W = 5;

   // Encoding 2'b11 is an alias of MODE_AND.
   function automatic mode_e norm_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'b00:   r = MODE_A;
         2'b01:   r = MODE_B;
         default: r = MODE_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Drives v1..v5 with handshaked timed sequences (branch A: v1,v2; branch B: v3,v4,v5).
// Build with SEQ_PATTERN_GEN_ERR_INJ_EN to let inject_err suppress the final event of a run.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned GAP   = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             inject_err,
   output logic             busy,
   output logic             done,
   output logic             v1,
   output logic             v2,
   output logic             v3,
   output logic             v4,
   output logic             v5,
   output logic [CNT_W-1:0] seq_cnt
);

   if (GAP < 1 || GAP > GAP_MAX) begin : g_gap_check
      $error("seq_pattern_gen: GAP out of range");
   end

   localparam logic [TIMER_W-1:0] GapT  = TIMER_W'(GAP);
   localparam logic [TIMER_W-1:0] Gap2T = TIMER_W'(2 * GAP);

   state_e             state_q;
   mode_e              mode_q;
   logic               err_q;
   logic [TIMER_W-1:0] t_q;
   logic               busy_q;
   logic               done_q;
   logic [4:0]         ev_q;
   logic [CNT_W-1:0]   cnt_q;

   mode_e              mode_in;
   logic               err_in;
   logic [TIMER_W-1:0] t_d;
   logic [TIMER_W-1:0] last;

   // Event vector for relative time t; bit i drives v(i+1).
   function automatic logic [4:0] events_at(input logic [TIMER_W-1:0] t, input mode_e m,
                                            input logic err);
      logic       a;
      logic       b;
      logic [4:0] ev;
      a     = (m != MODE_B);
      b     = (m != MODE_A);
      ev[0] = a && (t == '0);
      ev[1] = a && (t == GapT) && !(err && (m == MODE_A));
      ev[2] = b && (t == '0);
      ev[3] = b && (t == GapT);
      ev[4] = b && (t == Gap2T) && !err;
      return ev;
   endfunction

`ifdef SEQ_PATTERN_GEN_ERR_INJ_EN
   assign err_in = inject_err;
`else
   logic unused_inject_err;
   assign unused_inject_err = inject_err;
   assign err_in = 1'b0;
`endif

   always_comb begin
      mode_in = norm_mode(mode);
      t_d     = t_q + TIMER_W'(1);
      last    = (mode_q == MODE_A) ? GapT : Gap2T;
   end

   // Outputs are registered alongside the state so each event lands exactly on edge k+t.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_A;
         err_q   <= 1'b0;
         t_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ev_q    <= '0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         ev_q   <= '0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  mode_q  <= mode_in;
                  err_q   <= err_in;
                  t_q     <= '0;
                  busy_q  <= 1'b1;
                  ev_q    <= events_at('0, mode_in, err_in);
               end
            end
            RUN: begin
               t_q  <= t_d;
               ev_q <= events_at(t_d, mode_q, err_q);
               if (t_d == last) state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               cnt_q   <= cnt_q + CNT_W'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign v1      = ev_q[0];
   assign v2      = ev_q[1];
   assign v3      = ev_q[2];
   assign v4      = ev_q[3];
   assign v5      = ev_q[4];
   assign seq_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized scoreboard bench for seq_pattern_gen: a timeline model plans whole runs,
// a negedge monitor pops one expected frame per cycle for two DUTs (CNT_W=8 and CNT_W=2).
module tb_seq_pattern_gen;

   localparam int unsigned GAP = 2;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [4:0]  v;
      logic [31:0] cnt;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic       inject_err;

   logic       busy_a, done_a, v1_a, v2_a, v3_a, v4_a, v5_a;
   logic [7:0] cnt_a;
   logic       busy_b, done_b, v1_b, v2_b, v3_b, v4_b, v5_b;
   logic [1:0] cnt_b;

   frame_t      exp_q[$];
   frame_t      plan[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cnt_m  = '0;
   int          cyc    = 0;

   seq_pattern_gen #(.GAP(GAP), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .inject_err(inject_err),
      .busy(busy_a), .done(done_a), .v1(v1_a), .v2(v2_a), .v3(v3_a), .v4(v4_a), .v5(v5_a),
      .seq_cnt(cnt_a)
   );

   seq_pattern_gen #(.GAP(GAP), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .inject_err(inject_err),
      .busy(busy_b), .done(done_b), .v1(v1_b), .v2(v2_b), .v3(v3_b), .v4(v4_b), .v5(v5_b),
      .seq_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   // Plan every frame of one accepted run: events by schedule, then the done frame.
   task automatic plan_run(input logic [1:0] m, input logic e);
      int     ev_t[5];
      int     last;
      int     latest;
      logic   err;
      frame_t f;
`ifdef SEQ_PATTERN_GEN_ERR_INJ_EN
      err = e;
`else
      err = 1'b0;
`endif
      for (int i = 0; i < 5; i++) ev_t[i] = -1;
      if (m != 2'b01) begin ev_t[0] = 0; ev_t[1] = GAP; end
      if (m != 2'b00) begin ev_t[2] = 0; ev_t[3] = GAP; ev_t[4] = 2 * GAP; end
      last = 0;
      for (int i = 0; i < 5; i++) if (ev_t[i] > last) last = ev_t[i];
      if (err) begin
         latest = 0;
         for (int i = 0; i < 5; i++) if (ev_t[i] == last) latest = i;
         ev_t[latest] = -1;
      end
      for (int r = 0; r <= last; r++) begin
         f      = '0;
         f.busy = 1'b1;
         f.cnt  = cnt_m;
         for (int i = 0; i < 5; i++) f.v[i] = (ev_t[i] == r);
         plan.push_back(f);
      end
      cnt_m  = cnt_m + 1;
      f      = '0;
      f.done = 1'b1;
      f.cnt  = cnt_m;
      plan.push_back(f);
   endtask

   task automatic step(input logic r, input logic s, input logic [1:0] m, input logic e);
      frame_t f;
      rst        = r;
      start      = s;
      mode       = m;
      inject_err = e;
      if (r) begin
         plan.delete();
         cnt_m = '0;
      end else if (plan.size() == 0 && s) begin
         plan_run(m, e);
      end
      if (!r && plan.size() > 0) begin
         f = plan.pop_front();
      end else begin
         f     = '0;
         f.cnt = cnt_m;
      end
      exp_q.push_back(f);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      frame_t f;
      logic [38:0] got_a, want_a;
      logic [32:0] got_b, want_b;
      if (exp_q.size() > 0) begin
         f      = exp_q.pop_front();
         got_a  = {busy_a, done_a, v5_a, v4_a, v3_a, v2_a, v1_a, 24'd0, cnt_a};
         want_a = {f.busy, f.done, f.v, 24'd0, f.cnt[7:0]};
         got_b  = {busy_b, done_b, v5_b, v4_b, v3_b, v2_b, v1_b, 24'd0, cnt_b};
         want_b = {f.busy, f.done, f.v, 24'd0, f.cnt[1:0]};
         checks++;
         if (got_a !== want_a) begin
            errors++;
            $display("FAIL dut_a cyc=%0d got busy=%b done=%b v5..1=%b cnt=%0d want busy=%b done=%b v5..1=%b cnt=%0d",
                     cyc, busy_a, done_a, {v5_a, v4_a, v3_a, v2_a, v1_a}, cnt_a,
                     f.busy, f.done, f.v, f.cnt[7:0]);
         end
         checks++;
         if (got_b !== want_b) begin
            errors++;
            $display("FAIL dut_b cyc=%0d got busy=%b done=%b v5..1=%b cnt=%0d want busy=%b done=%b v5..1=%b cnt=%0d",
                     cyc, busy_b, done_b, {v5_b, v4_b, v3_b, v2_b, v1_b}, cnt_b,
                     f.busy, f.done, f.v, f.cnt[1:0]);
         end
         cyc++;
      end
   end

   initial begin
      step(1'b1, 1'b0, 2'b00, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
      // Directed: each mode once, with and without error injection, then held start.
      for (int m = 0; m < 4; m++) begin
         step(1'b0, 1'b1, 2'(m), 1'b0);
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
         step(1'b0, 1'b1, 2'(m), 1'b1);
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
      end
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b10, 1'b0);
      step(1'b0, 1'b1, 2'b10, 1'b0);
      step(1'b0, 1'b0, 2'b00, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending frames want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Synthesizable stimulus generator that drives the five-signal event bus (v1..v5) with the two timed sequences our concurrent-assertion checkers monitor. Branch A is v1 followed GAP cycles later by v2. Branch B is v3, then v4 GAP cycles later, then v5 GAP cycles after that. It sits in front of the assertion checker, replacing free-running counter stimulus with deterministic, handshaked sequences, and can deliberately break one to prove the checker fires.

## Interface
Parameters:
- GAP, 2: cycles between consecutive events in a branch; legal range 1..15.
- CNT_W, 8: width of the completed-sequence counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one sequence run; sampled only in IDLE.
- mode  in  2  00 = branch A only, 01 = branch B only, 10 = both (AND), 11 = treated as 10.
- inject_err  in  1  sampled with start; suppresses the final event of the run.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- v1, v2, v3, v4, v5  out  1 each  event outputs, registered, one-cycle pulses.
- seq_cnt  out  CNT_W  number of runs completed since reset; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE when t == LAST.
  - DONE -> IDLE unconditionally.
- Entry to RUN:
  - mode and inject_err are latched into mode_q and err_q.
  - Timer t is set to 0.
- While in RUN, t increments by 1 per cycle.
- LAST is fixed per run:
  - GAP when mode_q = 00.
  - 2*GAP otherwise.
- Event schedule, relative to t:
  - Branch A active (mode_q = 00, 10 or 11): v1 at t=0, v2 at t=GAP.
  - Branch B active (mode_q = 01, 10 or 11): v3 at t=0, v4 at t=GAP, v5 at t=2*GAP.
- Error injection: when err_q=1, the final event is held low. That is v2 for mode 00, otherwise v5. All other events are unchanged.
- In DONE, done=1 and seq_cnt increments by 1 (wraps).
- start while busy or in DONE is ignored. It is not queued.
- mode and inject_err changes during RUN have no effect.
- Timer width is 5 bits, enough for 2*GAP ≤ 30.

## Timing
- Reset values: busy=0, done=0, v1..v5=0, seq_cnt=0, state=IDLE.
- start is sampled high at edge k.
  - busy and the t=0 events are high from edge k.
  - The event at relative time t is high from edge k+t, for exactly one cycle.
- busy stays high for LAST+1 cycles, from edge k through edge k+LAST, and is low from edge k+LAST+1.
- done is high from edge k+LAST+1 for one cycle; seq_cnt updates at the same edge.
- Earliest next start is sampled at edge k+LAST+2 (IDLE), so runs are separated by at least one idle cycle.
- Reset asserted mid-run: at the next edge all outputs return to their reset values and the state goes to IDLE. No done pulse. The partial run is not counted.
- If rst and start are high at the same edge, rst wins.

## Configuration
- Macro: SEQ_PATTERN_GEN_ERR_INJ_EN.
- Defined: inject_err behaves as described in Operation.
- Undefined:
  - The inject_err port still exists but is ignored.
  - err_q is tied to 0.
  - Every run produces the complete sequence.

## Structure
- Shared package seq_gen_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the mode typedef (MODE_A = 2'b00, MODE_B = 2'b01, MODE_AND = 2'b10);
  - the GAP limit constant, GAP_MAX = 15.
- No sub-module. FSM, timer and event decode stay in one module; the event decode is a compare of t against 0, GAP and 2*GAP.

## Test plan
All scenarios use GAP=2.
- Reset then idle: no start for 10 cycles -> v1..v5, busy and done all 0; seq_cnt = 0.
- mode=00, start at edge 5:
  - v1 at 5, v2 at 7, v3..v5 never;
  - busy during 5..7; done at 8; seq_cnt = 1.
- mode=10, start at edge 5:
  - v1 and v3 at 5, v2 and v4 at 7, v5 at 9;
  - busy during 5..9; done at 10; bound AND and OR assertions both pass.
- mode=01 with inject_err=1 and the macro defined:
  - v3 at 5, v4 at 7, v5 stays 0;
  - the bound checker reports a failure; done at 10.
  - Same stimulus with the macro undefined -> v5 at 9.
- start held high continuously with mode=10: runs start at 5, 11 and 17 (one idle cycle between runs); seq_cnt counts 1, 2, 3.
- rst pulsed at edge 7 during a mode=10 run:
  - from edge 7, v4 and v5 do not appear and there is no done;
  - busy = 0; seq_cnt remains at its prior value.
- CNT_W=2 with 5 back-to-back runs -> seq_cnt goes 1, 2, 3, 0, 1.
